// File: rtl/ctrl_pkg.sv
// Shared types for the nibble steering path: nibble width, slot index and slot count.
package ctrl_pkg;

    localparam int NIBBLE_W = 4;
    localparam int NSLOTS   = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;
    typedef logic [1:0]          slot_t;

endpackage

// File: rtl/dec2_4.sv
// 2-to-4 one-hot decoder gated by an enable; drives the staging bank write enables.
module dec2_4
    import ctrl_pkg::*;
(
    input  logic       en,
    input  slot_t      sel,
    output logic [3:0] onehot
);

    assign onehot = en ? (4'b0001 << sel) : 4'b0000;

endmodule

// File: rtl/nibble_demux4.sv
// Steers a handshaked nibble stream round-robin into a staging bank, then moves
// each complete frame into a held output bank Q0..Q3 (double-buffered).
module nibble_demux4
    import ctrl_pkg::*;
#(
    parameter int W = NIBBLE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] Q0,
    output logic [W-1:0] Q1,
    output logic [W-1:0] Q2,
    output logic [W-1:0] Q3,
    output slot_t        cur_slot,
    output logic         sync_err
);

    slot_t        idx;
    logic         stage_full;
    logic [W-1:0] staging [NSLOTS];
    logic         accept;
    logic         transfer;
    slot_t        slot;
    logic [3:0]   wr_en;

    // in_ready comes straight from a register, so out_ready never reaches it combinationally
    assign in_ready = !stage_full;
    assign accept   = in_valid && in_ready;
    assign slot     = in_first ? 2'd0 : idx;
    assign transfer = stage_full && (!out_valid || out_ready);
    assign cur_slot = idx;

    dec2_4 u_dec (
        .en     (accept),
        .sel    (slot),
        .onehot (wr_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            stage_full <= 1'b0;
            out_valid  <= 1'b0;
            sync_err   <= 1'b0;
            Q0         <= '0;
            Q1         <= '0;
            Q2         <= '0;
            Q3         <= '0;
            for (int i = 0; i < NSLOTS; i++) begin
                staging[i] <= '0;
            end
        end else begin
            sync_err <= accept && in_first && (idx != 2'd0);

            if (accept) begin
                idx <= slot_t'(slot + 2'd1);
            end

            for (int i = 0; i < NSLOTS; i++) begin
                if (wr_en[i]) begin
                    staging[i] <= in_data;
                end
            end

            // accept and transfer are mutually exclusive: one needs stage_full low, the other high
            if (transfer) begin
                stage_full <= 1'b0;
            end else if (accept && slot == 2'd3) begin
                stage_full <= 1'b1;
            end

            if (transfer) begin
                Q0        <= staging[0];
                Q1        <= staging[1];
                Q2        <= staging[2];
                Q3        <= staging[3];
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nibble_demux4.sv
// Scoreboard bench: stimulus queues expected frames, a negedge monitor checks each
// consumed frame in order and that Q holds steady while the frame waits.
module tb_nibble_demux4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = 4'h0;
    logic        in_first = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  Q0, Q1, Q2, Q3;
    logic [1:0]  cur_slot;
    logic        sync_err;

    logic [15:0] sb[$];
    logic [15:0] q_packed;
    logic [15:0] prev_q = '0;
    logic        prev_hold = 1'b0;
    logic        rand_mode = 1'b0;
    int          checks = 0;
    int          errors = 0;

    assign q_packed = {Q0, Q1, Q2, Q3};

    nibble_demux4 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Q0        (Q0),
        .Q1        (Q1),
        .Q2        (Q2),
        .Q3        (Q3),
        .cur_slot  (cur_slot),
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one nibble and return #1 after the edge on which it was accepted
    task automatic apply_stimulus(input logic [3:0] d, input logic f);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_first = f;
        @(negedge clk);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check_output("send_timeout", 16'd0, 16'd1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        check_output("drain_empty", 16'(sb.size()), 16'd0);
    endtask

    always @(negedge clk) begin
        if (prev_hold) begin
            check_output("q_stable", q_packed, prev_q);
        end
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check_output("unexpected_frame", q_packed, 16'hxxxx);
            end else begin
                check_output("frame", q_packed, sb.pop_front());
            end
        end
        prev_hold <= out_valid && !out_ready && !rst;
        prev_q    <= q_packed;
    end

    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] frame;

        // reset state
        step(3);
        rst = 1'b0;
        check_output("rst_in_ready", 16'(in_ready), 16'd1);
        check_output("rst_out_valid", 16'(out_valid), 16'd0);
        check_output("rst_q", q_packed, 16'h0000);
        check_output("rst_cur_slot", 16'(cur_slot), 16'd0);
        check_output("rst_sync_err", 16'(sync_err), 16'd0);

        // back-to-back frame, one stall cycle, Q two cycles after last accept
        out_ready = 1'b1;
        sb.push_back(16'h1234);
        apply_stimulus(4'h1, 1'b0);
        apply_stimulus(4'h2, 1'b0);
        apply_stimulus(4'h3, 1'b0);
        check_output("t1_cur_slot", 16'(cur_slot), 16'd3);
        apply_stimulus(4'h4, 1'b0);
        check_output("t1_stall", 16'(in_ready), 16'd0);
        check_output("t1_wrap", 16'(cur_slot), 16'd0);
        step(1);
        check_output("t1_ready_back", 16'(in_ready), 16'd1);
        check_output("t1_out_valid", 16'(out_valid), 16'd1);
        check_output("t1_q", q_packed, 16'h1234);
        step(1);
        check_output("t1_consumed", 16'(out_valid), 16'd0);

        // backpressure: second frame waits in staging, then loads with no bubble
        out_ready = 1'b0;
        sb.push_back(16'hABCD);
        sb.push_back(16'h5678);
        apply_stimulus(4'hA, 1'b0);
        apply_stimulus(4'hB, 1'b0);
        apply_stimulus(4'hC, 1'b0);
        apply_stimulus(4'hD, 1'b0);
        apply_stimulus(4'h5, 1'b0);
        apply_stimulus(4'h6, 1'b0);
        apply_stimulus(4'h7, 1'b0);
        apply_stimulus(4'h8, 1'b0);
        check_output("t2_in_ready_low", 16'(in_ready), 16'd0);
        step(3);
        check_output("t2_still_low", 16'(in_ready), 16'd0);
        check_output("t2_q_held", q_packed, 16'hABCD);
        check_output("t2_out_valid", 16'(out_valid), 16'd1);
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("t2_no_bubble", 16'(out_valid), 16'd1);
        check_output("t2_q_new", q_packed, 16'h5678);
        step(2);
        drain();

        // resync: in_first at idx 0 is silent, at idx 2 pulses sync_err once
        sb.push_back(16'hBCDE);
        apply_stimulus(4'h9, 1'b1);
        check_output("t3_first_at_0", 16'(sync_err), 16'd0);
        apply_stimulus(4'hA, 1'b0);
        apply_stimulus(4'hB, 1'b1);
        check_output("t3_sync_err", 16'(sync_err), 16'd1);
        check_output("t3_resync_slot", 16'(cur_slot), 16'd1);
        apply_stimulus(4'hC, 1'b0);
        check_output("t3_pulse_once", 16'(sync_err), 16'd0);
        apply_stimulus(4'hD, 1'b0);
        apply_stimulus(4'hE, 1'b0);
        drain();

        // mid-operation reset discards the held frame and the partial one
        out_ready = 1'b0;
        apply_stimulus(4'h1, 1'b0);
        apply_stimulus(4'h2, 1'b0);
        apply_stimulus(4'h3, 1'b0);
        apply_stimulus(4'h4, 1'b0);
        step(2);
        apply_stimulus(4'h5, 1'b0);
        apply_stimulus(4'h6, 1'b0);
        check_output("t4_pre_valid", 16'(out_valid), 16'd1);
        check_output("t4_pre_slot", 16'(cur_slot), 16'd2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_output("t4_out_valid", 16'(out_valid), 16'd0);
        check_output("t4_q", q_packed, 16'h0000);
        check_output("t4_cur_slot", 16'(cur_slot), 16'd0);
        check_output("t4_in_ready", 16'(in_ready), 16'd1);

        // random gaps and consumer stalls over many frames
        rand_mode = 1'b1;
        for (int fr = 0; fr < 1000; fr++) begin
            frame = 16'($urandom);
            sb.push_back(frame);
            for (int s = 0; s < 4; s++) begin
                repeat ($urandom_range(0, 1)) begin
                    in_data = 4'($urandom);
                    step(1);
                end
                apply_stimulus(frame[15 - 4*s -: 4], (s == 0) ? 1'($urandom_range(0, 1)) : 1'b0);
            end
        end
        rand_mode = 1'b0;
        step(1);
        out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
